toggle_sched: RTL and testbench
===============================

Name: toggle_sched

Overview:
- Round-robin scheduler that shares one downstream toggle_module between NUM_REQ requesters.
- Each requester submits a burst request: "toggle the shared output N times". The scheduler serialises bursts and drives the single-bit toggle input of the shared toggle_module.
- It enforces a programmable idle gap between toggle pulses and reports completion per requester.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- CNT_W, 4: width of each burst count; max burst is 2^CNT_W-1.
- GAP, 1: idle cycles forced between consecutive toggle pulses of one burst; 0 is legal.
- IDX_W, $clog2(NUM_REQ): width of the owner index.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester burst request.
- req_count  in  NUM_REQ*CNT_W  packed burst lengths; slice i = [i*CNT_W +: CNT_W].
- req_ready  out  NUM_REQ  combinational accept, one-hot or zero.
- toggle  out  1  registered pulse to toggle_module.toggle.
- busy  out  1  high while a burst is in progress.
- owner  out  IDX_W  index of the current or last granted requester.
- done  out  NUM_REQ  one-cycle completion pulse per requester.

Behaviour:
- Reset (rst_n=0 sampled at posedge clk):
  - Next cycle: toggle=0, busy=0, done=0, owner=0, state=IDLE, remaining=0, gap counter=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has top priority.
  - Reset mid-burst discards the burst: no further pulses, no done.
- FSM states: IDLE, PULSE, GAP.
- Handshake:
  - req_ready[g]=1 only in IDLE, and only for the winner g.
  - The winner is the first index with req_valid set, searching from last_grant+1 with wrap-around.
  - Transfer occurs on a posedge with req_valid[g] & req_ready[g].
  - Requesters hold req_valid and req_count stable until accepted. Dropping req_valid before acceptance is legal; the arbiter re-evaluates every cycle.
- On accept of requester g with count c:
  - last_grant←g, owner←g.
  - c=0: stay IDLE; done[g]=1 the next cycle; toggle stays 0.
  - c>0: remaining←c, go to PULSE.
- PULSE:
  - Outputs: toggle=1, busy=1, one cycle.
  - remaining decrements at the end of the cycle.
  - remaining was 1: go to IDLE; done[g]=1 in the following cycle.
  - Otherwise, GAP>0: go to GAP with the counter loaded to GAP.
  - Otherwise, GAP=0: stay in PULSE, so toggle is high on consecutive cycles.
- GAP:
  - Outputs: toggle=0, busy=1.
  - Counter decrements each cycle; at 1, go to PULSE.
- After each burst, the FSM spends at least one IDLE cycle before granting again.
  - Arbitration may accept a new request in that IDLE cycle, the same cycle done is high.
- Timing:
  - Latency from accept edge to first toggle: 0 cycles; toggle is high in the cycle after the accept edge.
  - Burst length on the wire: c + (c-1)*GAP cycles.
- Invariants:
  - toggle=1 implies busy=1.
  - done is one-hot or zero.
  - req_ready=0 whenever busy=1.
  - Exactly c toggle pulses per accepted burst unless reset intervenes.
- owner holds its value in IDLE; it is only updated on accept.
- Width: remaining is CNT_W bits; a burst of 2^CNT_W-1 must complete without wrap.

Test Plan:
- Single burst: req_valid[0]=1, count=3, GAP=1 → accept at edge 0; toggle pattern 1,0,1,0,1; done[0] high in cycle 6; shared out flips 3 times; busy high 5 cycles.
- Fairness: all four requesters valid, count=1 each → grants in order 0,1,2,3, each one pulse with an IDLE cycle between; requester 0 re-requests after grant 3 and is granted next.
- Wrap-around: last_grant=2, req_valid=4'b1010 → requester 3 granted; then with req_valid=4'b0010 → requester 1 granted.
- Zero count: req_valid[2]=1, count=0 → req_ready[2]=1 for one cycle; done[2] next cycle; toggle stays 0; busy stays 0.
- GAP=0 build with count=4 → toggle high 4 consecutive cycles; done one cycle after; max count=15 yields exactly 15 pulses.
- Reset mid-burst: count=5, rst_n=0 after the 2nd pulse → toggle=0, busy=0, no done; after release, requester 0 has priority over pending requester 3.

Source files
------------

// File: rtl/toggle_sched_if.sv
// Request/response bundle between requesters and the toggle scheduler.
// master = requester side, slave = scheduler side.
interface toggle_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*CNT_W-1:0] req_count;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     toggle;
    logic                     busy;
    logic [IDX_W-1:0]         owner;
    logic [NUM_REQ-1:0]       done;

    modport master (
        output req_valid, req_count,
        input  req_ready, toggle, busy, owner, done
    );

    modport slave (
        input  req_valid, req_count,
        output req_ready, toggle, busy, owner, done
    );
endinterface

// File: rtl/toggle_sched.sv
// Round-robin scheduler serialising toggle bursts from NUM_REQ requesters onto one
// shared toggle line, with GAP idle cycles between pulses and per-requester done pulses.
module toggle_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned GAP     = 1,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input logic           clk,
    input logic           rst_n,
    toggle_sched_if.slave bus
);
    localparam int unsigned       GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned       IDX_W1   = IDX_W + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]    NUM_REQ_W = IDX_W1'(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               toggle_q;
    logic               busy_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;
    logic [CNT_W-1:0]   win_count;
    logic [NUM_REQ-1:0] ready;
    logic               accept;

    // Search starts just after the last grant and wraps, so the last winner is lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + IDX_W1'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_count = bus.req_count[win_idx*CNT_W +: CNT_W];
    assign ready     = (state_q == StIdle && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
    assign accept    = |(bus.req_valid & ready);

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        gap_d        = gap_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        done_d       = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = win_idx;
                    owner_d      = win_idx;
                    if (win_count == '0) begin
                        done_d = NUM_REQ'(1) << win_idx;
                    end else begin
                        remaining_d = win_count;
                        state_d     = StPulse;
                    end
                end
            end
            StPulse: begin
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = NUM_REQ'(1) << owner_q;
                end else if (GAP > 0) begin
                    gap_d   = GAP_W'(GAP);
                    state_d = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = StPulse;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            gap_q        <= '0;
            last_grant_q <= LAST_IDX;
            owner_q      <= '0;
            done_q       <= '0;
            toggle_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            gap_q        <= gap_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            done_q       <= done_d;
            // Registered straight from the next state so toggle leaves a flop, glitch-free.
            toggle_q     <= (state_d == StPulse);
            busy_q       <= (state_d != StIdle);
        end
    end

    assign bus.req_ready = ready;
    assign bus.toggle    = toggle_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_toggle_sched.sv
// Random + directed bench for toggle_sched: GAP=1 and GAP=0 instances, each checked by a
// timing-level reference model feeding a scoreboard drained by an independent monitor.
module tb_toggle_sched;
    localparam int unsigned NR    = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned IW    = 2;
    localparam int          GAP_A = 1;
    localparam int          GAP_B = 0;

    typedef struct {
        int g;
        int c;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   in_reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, one slot per DUT instance.
    bit   pend [2][NR];
    int   pcnt [2][NR];
    int   free_at [2];
    int   last_g [2];
    int   own_m [2];
    exp_t q_a[$];
    exp_t q_b[$];
    int   npl [2];
    int   last_pl [2];

    toggle_sched_if #(.NUM_REQ(NR), .CNT_W(CW), .IDX_W(IW)) if_a ();
    toggle_sched_if #(.NUM_REQ(NR), .CNT_W(CW), .IDX_W(IW)) if_b ();

    toggle_sched #(.NUM_REQ(NR), .CNT_W(CW), .GAP(GAP_A), .IDX_W(IW)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    toggle_sched #(.NUM_REQ(NR), .CNT_W(CW), .GAP(GAP_B), .IDX_W(IW)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP_A : GAP_B;
    endfunction

    function automatic int burst_len(input int d, input int c);
        return (c == 0) ? 0 : c + (c - 1) * gap_of(d);
    endfunction

    function automatic logic [NR-1:0] get_ready(input int d);
        return (d == 0) ? if_a.req_ready : if_b.req_ready;
    endfunction
    function automatic logic get_toggle(input int d);
        return (d == 0) ? if_a.toggle : if_b.toggle;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 0) ? if_a.busy : if_b.busy;
    endfunction
    function automatic logic [IW-1:0] get_owner(input int d);
        return (d == 0) ? if_a.owner : if_b.owner;
    endfunction
    function automatic logic [NR-1:0] get_done(input int d);
        return (d == 0) ? if_a.done : if_b.done;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction
    function automatic exp_t q_front(input int d);
        return (d == 0) ? q_a[0] : q_b[0];
    endfunction

    task automatic q_push(input int d, input exp_t e);
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic q_pop(input int d, output exp_t e);
        if (d == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    // Round-robin rule: first pending index after the last grant, wrapping.
    function automatic int rr_win(input int d);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last_g[d] + k) % NR;
            if (pend[d][i]) return i;
        end
        return -1;
    endfunction

    task automatic post(input int r, input int c);
        for (int d = 0; d < 2; d++) begin
            pend[d][r] = 1'b1;
            pcnt[d][r] = c;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0;
            last_g[d]  = NR - 1;
            own_m[d]   = 0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if_a.req_valid[r]           = pend[0][r];
            if_a.req_count[r*CW +: CW]  = CW'(pcnt[0][r]);
            if_b.req_valid[r]           = pend[1][r];
            if_b.req_count[r*CW +: CW]  = CW'(pcnt[1][r]);
        end
    endtask

    // One clock of stimulus + model; rst asserts synchronous reset for the coming edge.
    task automatic step(input bit rst);
        @(negedge clk);
        cyc++;
        rst_n    = !rst;
        in_reset = rst;
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, get_busy(d), cyc < free_at[d]);
                chk("owner", d, get_owner(d), own_m[d]);
            end
        end
        drive();
        #1;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                int   w;
                exp_t e;
                w = (cyc >= free_at[d]) ? rr_win(d) : -1;
                chk("req_ready", d, get_ready(d), (w >= 0) ? (32'd1 << w) : 32'd0);
                if (w >= 0) begin
                    e.g = w;
                    e.c = pcnt[d][w];
                    e.t = cyc;
                    q_push(d, e);
                    last_g[d]  = w;
                    own_m[d]   = w;
                    free_at[d] = cyc + burst_len(d, e.c) + 1;
                    pend[d][w] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain();
        bit idle;
        for (int n = 0; n < 400; n++) begin
            idle = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (cyc < free_at[d]) idle = 1'b0;
                for (int r = 0; r < NR; r++) if (pend[d][r]) idle = 1'b0;
            end
            if (idle) return;
            step(1'b0);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout cycle %0d: got busy, expected idle within 400 cycles", cyc);
    endtask

    task automatic mon_one(input int d);
        logic          tg;
        logic [NR-1:0] dn;
        int            qn;
        exp_t          e;
        if (in_reset) begin
            npl[d] = 0;
            return;
        end
        tg = get_toggle(d);
        dn = get_done(d);
        qn = q_size(d);
        chk("stray_toggle", d, tg && (qn == 0), 0);
        chk("stray_done", d, (dn != '0) && (qn == 0), 0);
        if (tg === 1'b1) begin
            chk("toggle_implies_busy", d, get_busy(d), 1);
            if (qn > 0) begin
                e = q_front(d);
                if (npl[d] == 0) chk("first_pulse_cycle", d, cyc, e.t + 1);
                else chk("pulse_spacing", d, cyc - last_pl[d], gap_of(d) + 1);
            end
            npl[d]++;
            last_pl[d] = cyc;
        end
        if (dn != '0 && qn > 0) begin
            chk("done_onehot", d, $onehot(dn), 1);
            q_pop(d, e);
            chk("done_index", d, dn, 32'd1 << e.g);
            chk("pulse_count", d, npl[d], e.c);
            chk("done_cycle", d, cyc, e.t + burst_len(d, e.c) + 1);
            chk("owner_at_done", d, get_owner(d), e.g);
            npl[d] = 0;
        end
    endtask

    // Monitor runs after the stimulus process has finished its work for the cycle.
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) mon_one(d);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NR; r++) begin
                pend[d][r] = 1'b0;
                pcnt[d][r] = 0;
            end
            npl[d]     = 0;
            last_pl[d] = 0;
        end
        model_reset();
        drive();
        step(1'b1);
        step(1'b1);

        post(0, 3);
        drain();

        for (int r = 0; r < NR; r++) post(r, 1);
        drain();
        post(2, 1);
        post(0, 1);
        drain();

        post(2, 1);
        drain();
        post(3, 1);
        post(1, 1);
        drain();

        post(2, 0);
        drain();

        post(0, 4);
        drain();
        post(0, 15);
        drain();

        post(0, 5);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        post(3, 2);
        step(1'b1);
        post(0, 1);
        drain();

        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < NR; r++) begin
                    if (!pend[d][r] && ($urandom % 5 == 0)) begin
                        pend[d][r] = 1'b1;
                        pcnt[d][r] = ($urandom % 8 == 0) ? 15 : int'($urandom_range(0, 6));
                    end else if (pend[d][r] && ($urandom % 32 == 0)) begin
                        pend[d][r] = 1'b0;
                    end
                end
            end
            step($urandom % 400 == 0);
        end

        drain();
        step(1'b0);
        step(1'b0);
        step(1'b0);
        for (int d = 0; d < 2; d++) chk("scoreboard_empty", d, q_size(d), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
